// File: rtl/ca_life_engine.sv
// One-dimensional elementary cellular automaton (Wolfram rule) with serial
// loading, single-step and prescaled free-running step modes.
module ca_life_engine #(
  parameter int WIDTH = 8,
  parameter int GEN_W = 16,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       rule,
  input  logic             load_valid,
  input  logic             load_bit,
  output logic             load_ready,
  input  logic             step_req,
  input  logic             run,
  input  logic [7:0]       period,
  output logic [WIDTH-1:0] cells,
  output logic [GEN_W-1:0] gen_count,
  output logic             alive,
  output logic             stable,
  output logic             step_done,
  output logic             load_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cells_q, cells_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         presc_q, presc_d;
  logic               alive_q, alive_d;
  logic               stable_q, stable_d;
  logic               step_done_q, step_done_d;
  logic               load_done_q, load_done_d;
  logic               load_ready_q, load_ready_d;
  logic [WIDTH-1:0]   next_s;
  logic [7:0]         p_eff_s;
  logic               do_step_s;

  // Neighbours outside the row read as 0 unless the row is a torus.
  function automatic logic [WIDTH-1:0] next_gen(input logic [WIDTH-1:0] c,
                                                input logic [7:0] r);
    logic [WIDTH-1:0] n;
    logic             l, s, rt;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s  = c[i];
      l  = (WRAP || (i != WIDTH - 1)) ? c[(i + 1) % WIDTH] : 1'b0;
      rt = (WRAP || (i != 0)) ? c[(i + WIDTH - 1) % WIDTH] : 1'b0;
      n[i] = r[{l, s, rt}];
    end
    return n;
  endfunction

  always_comb begin
    state_d      = state_q;
    cells_d      = cells_q;
    gen_d        = gen_q;
    cnt_d        = cnt_q;
    presc_d      = presc_q;
    stable_d     = stable_q;
    step_done_d  = 1'b0;
    load_done_d  = 1'b0;
    do_step_s    = 1'b0;
    next_s       = next_gen(cells_q, rule);
    p_eff_s      = (period == 8'd0) ? 8'd1 : period;

    if (ena) begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            state_d = LOAD;
            cells_d = {cells_q[WIDTH-2:0], load_bit};
            cnt_d   = CNT_W'(1);
            presc_d = 8'd0;
          end else begin
            if (step_req) begin
              do_step_s = 1'b1;
              presc_d   = 8'd0;
            end else if (run) begin
              // presc_q never exceeds 254, so the increment cannot overflow.
              if ((presc_q + 8'd1) >= p_eff_s) begin
                do_step_s = 1'b1;
                presc_d   = 8'd0;
              end else begin
                presc_d = presc_q + 8'd1;
              end
            end else begin
              presc_d = 8'd0;
            end
            if (do_step_s) begin
              cells_d     = next_s;
              gen_d       = gen_q + GEN_W'(1);
              step_done_d = 1'b1;
              stable_d    = (next_s == cells_q);
            end else begin
              cells_d = cells_q;
            end
          end
        end
        LOAD: begin
          presc_d = 8'd0;
          if (load_valid) begin
            cells_d = {cells_q[WIDTH-2:0], load_bit};
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_d     = IDLE;
              cnt_d       = '0;
              load_done_d = 1'b1;
              stable_d    = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          presc_d = 8'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    alive_d      = |cells_d;
    load_ready_d = (state_d == IDLE) || (state_d == LOAD);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cells_q      <= '0;
      gen_q        <= '0;
      cnt_q        <= '0;
      presc_q      <= 8'd0;
      alive_q      <= 1'b0;
      stable_q     <= 1'b0;
      step_done_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cells_q      <= cells_d;
      gen_q        <= gen_d;
      cnt_q        <= cnt_d;
      presc_q      <= presc_d;
      alive_q      <= alive_d;
      stable_q     <= stable_d;
      step_done_q  <= step_done_d;
      load_done_q  <= load_done_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign cells      = cells_q;
  assign gen_count  = gen_q;
  assign alive      = alive_q;
  assign stable     = stable_q;
  assign step_done  = step_done_q;
  assign load_done  = load_done_q;
  assign load_ready = load_ready_q;

endmodule

// File: tb/tb_ca_life_engine.sv
// Bench for ca_life_engine: WRAP=1 and WRAP=0 instances share stimulus and are
// checked each cycle against a behavioural model, plus literal pin checks.
module tb_ca_life_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena, load_valid, load_bit, step_req, run;
  logic [7:0] rule, period;

  logic [7:0]  cells_w, cells_n;
  logic [15:0] gen_w, gen_n;
  logic        alive_w, alive_n, stable_w, stable_n;
  logic        sd_w, sd_n, ld_w, ld_n, lr_w, lr_n;

  ca_life_engine #(.WIDTH(8), .GEN_W(16), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rule(rule),
    .load_valid(load_valid), .load_bit(load_bit), .load_ready(lr_w),
    .step_req(step_req), .run(run), .period(period),
    .cells(cells_w), .gen_count(gen_w), .alive(alive_w), .stable(stable_w),
    .step_done(sd_w), .load_done(ld_w)
  );

  ca_life_engine #(.WIDTH(8), .GEN_W(16), .WRAP(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rule(rule),
    .load_valid(load_valid), .load_bit(load_bit), .load_ready(lr_n),
    .step_req(step_req), .run(run), .period(period),
    .cells(cells_n), .gen_count(gen_n), .alive(alive_n), .stable(stable_n),
    .step_done(sd_n), .load_done(ld_n)
  );

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = toroidal row, index 1 = zero-padded row.
  bit [7:0] m_cells [2];
  bit       m_stable[2];
  int       m_gen, m_cnt, m_presc;
  bit       m_loading, m_sd, m_ld;

  function automatic bit [7:0] ref_next(input bit [7:0] c, input int r, input bit wrap);
    bit [7:0] n;
    int l, s, rt;
    for (int i = 0; i < 8; i++) begin
      s  = int'(c[i]);
      l  = (wrap || i < 7) ? int'(c[(i + 1) % 8]) : 0;
      rt = (wrap || i > 0) ? int'(c[(i + 7) % 8]) : 0;
      n[i] = bit'((r >> (4 * l + 2 * s + rt)) & 1);
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_cells[j]  = 8'h00;
      m_stable[j] = 1'b0;
    end
    m_gen = 0; m_cnt = 0; m_presc = 0;
    m_loading = 1'b0; m_sd = 1'b0; m_ld = 1'b0;
  endtask

  task automatic model_clock();
    int p;
    bit do_step;
    bit [7:0] nx;
    m_sd = 1'b0;
    m_ld = 1'b0;
    if (!ena) return;
    if (m_loading) begin
      m_presc = 0;
      if (load_valid) begin
        for (int j = 0; j < 2; j++) m_cells[j] = {m_cells[j][6:0], load_bit};
        m_cnt++;
        if (m_cnt == 8) begin
          m_loading = 1'b0;
          m_cnt = 0;
          m_ld = 1'b1;
          for (int j = 0; j < 2; j++) m_stable[j] = 1'b0;
        end
      end
    end else if (load_valid) begin
      for (int j = 0; j < 2; j++) m_cells[j] = {m_cells[j][6:0], load_bit};
      m_loading = 1'b1;
      m_cnt = 1;
      m_presc = 0;
    end else begin
      p = (period == 8'd0) ? 1 : int'(period);
      do_step = step_req;
      if (!run || step_req) m_presc = 0;
      else if (m_presc + 1 >= p) begin
        do_step = 1'b1;
        m_presc = 0;
      end else m_presc++;
      if (do_step) begin
        for (int j = 0; j < 2; j++) begin
          nx = ref_next(m_cells[j], int'(rule), (j == 0));
          m_stable[j] = (nx == m_cells[j]);
          m_cells[j] = nx;
        end
        m_gen = (m_gen + 1) % 65536;
        m_sd = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_clock();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("cells_wrap",  int'(cells_w),  int'(m_cells[0]));
        chk("cells_nowrap", int'(cells_n), int'(m_cells[1]));
        chk("gen_wrap",    int'(gen_w),    m_gen);
        chk("gen_nowrap",  int'(gen_n),    m_gen);
        chk("alive_wrap",  int'(alive_w),  int'(m_cells[0] != 8'h00));
        chk("alive_nowrap", int'(alive_n), int'(m_cells[1] != 8'h00));
        chk("stable_wrap", int'(stable_w), int'(m_stable[0]));
        chk("stable_nowrap", int'(stable_n), int'(m_stable[1]));
        chk("step_done_wrap", int'(sd_w), int'(m_sd));
        chk("step_done_nowrap", int'(sd_n), int'(m_sd));
        chk("load_done_wrap", int'(ld_w), int'(m_ld));
        chk("load_done_nowrap", int'(ld_n), int'(m_ld));
        chk("load_ready_wrap", int'(lr_w), 1);
        chk("load_ready_nowrap", int'(lr_n), 1);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      load_valid = 1'b1;
      load_bit   = v[i];
      cyc();
    end
    load_valid = 1'b0;
    load_bit   = 1'b0;
  endtask

  task automatic step_once();
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
  endtask

  int cnt;

  initial begin
    rst_n = 1'b1; ena = 1'b0; load_valid = 1'b0; load_bit = 1'b0;
    step_req = 1'b0; run = 1'b0; rule = 8'h00; period = 8'd0;
    #2 rst_n = 1'b0;
    checking = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    ena = 1'b1;

    chk("rst_cells", int'(cells_w), 8'h00);
    chk("rst_gen", int'(gen_w), 0);
    chk("rst_alive", int'(alive_w), 0);
    chk("rst_load_ready", int'(lr_w), 1);

    load_byte(8'h10);
    chk("load_0x10_cells", int'(cells_w), 8'h10);
    chk("load_0x10_done", int'(ld_w), 1);
    cyc();
    chk("load_done_one_pulse", int'(ld_w), 0);
    rule = 8'h5A;
    step_once();
    chk("r90_cells", int'(cells_w), 8'h28);
    chk("r90_gen", int'(gen_w), 1);
    chk("r90_step_done", int'(sd_w), 1);
    cyc();
    chk("step_done_one_pulse", int'(sd_w), 0);

    load_byte(8'h01);
    step_once();
    chk("edge_wrap", int'(cells_w), 8'h82);
    chk("edge_nowrap", int'(cells_n), 8'h02);

    load_byte(8'h3C);
    rule = 8'hCC;
    step_once();
    chk("identity_cells", int'(cells_w), 8'h3C);
    chk("identity_stable", int'(stable_w), 1);
    chk("identity_gen", int'(gen_w), 3);
    load_byte(8'h10);
    chk("stable_clr_on_load", int'(stable_w), 0);

    rule = 8'h5A; period = 8'd3; run = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      cnt += int'(sd_w);
      if (i == 3) chk("run_first_step_cells", int'(cells_w), 8'h28);
    end
    chk("run_steps_in_9", cnt, 3);
    ena = 1'b0;
    cnt = 0;
    repeat (5) begin cyc(); cnt += int'(sd_w); end
    chk("ena_low_no_steps", cnt, 0);
    ena = 1'b1;
    cnt = 0;
    repeat (6) begin cyc(); cnt += int'(sd_w); end
    chk("run_resume_steps", cnt, 2);
    run = 1'b0; period = 8'd0;
    cyc();

    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_bit = 1'b1; cyc();
    end
    rst_n = 1'b0;
    load_valid = 1'b0;
    cyc();
    chk("midload_rst_cells", int'(cells_w), 8'h00);
    chk("midload_rst_ready", int'(lr_w), 1);
    rst_n = 1'b1;
    cyc();
    load_valid = 1'b1; load_bit = 1'b1; step_req = 1'b1;
    cyc();
    step_req = 1'b0; load_valid = 1'b0;
    chk("load_wins_gen", int'(gen_w), 0);
    chk("load_wins_cells", int'(cells_w), 8'h01);
    chk("load_wins_no_step", int'(sd_w), 0);
    step_once();
    chk("step_in_load_ignored", int'(gen_w), 0);
    for (int i = 0; i < 7; i++) begin
      load_valid = 1'b1; load_bit = 1'($urandom_range(1)); cyc();
    end
    load_valid = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      ena        = ($urandom_range(9) != 0);
      load_valid = ($urandom_range(7) == 0);
      load_bit   = 1'($urandom_range(1));
      step_req   = ($urandom_range(5) == 0);
      if ($urandom_range(31) == 0) run = ~run;
      if ($urandom_range(63) == 0) period = 8'($urandom_range(4));
      if ($urandom_range(15) == 0) rule = 8'($urandom_range(255));
      if ($urandom_range(499) == 0) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ca_life_engine.md
CA_LIFE_ENGINE -- requirements
Module: ca_life_engine

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of cells (legal 8..64).
REQ-002 SHALL provide parameter GEN_W, default 16, generation-counter width.
REQ-003 SHALL provide parameter WRAP, default 1; 1 = toroidal row, 0 = cells outside the row read as 0.
REQ-004 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ena  input  1  global enable; when low, all state holds.
REQ-007 SHALL have rule  input  8  Wolfram rule byte.
REQ-008 SHALL have load_valid  input  1  serial load bit strobe.
REQ-009 SHALL have load_bit  input  1  serial load data.
REQ-010 SHALL have load_ready  output  1  high in IDLE and LOAD.
REQ-011 SHALL have step_req  input  1  single-step request pulse.
REQ-012 SHALL have run  input  1  free-running step mode.
REQ-013 SHALL have period  input  8  run-mode step period in ena cycles.
REQ-014 SHALL have cells  output  WIDTH  current generation.
REQ-015 SHALL have gen_count  output  GEN_W  generations computed since reset.
REQ-016 SHALL have alive  output  1  OR-reduction of cells.
REQ-017 SHALL have stable  output  1  last step produced no change.
REQ-018 SHALL have step_done, load_done  output  1 each  one-cycle pulses.

Function
REQ-019 SHALL implement FSM states IDLE and LOAD; all outputs registered.
REQ-020 In IDLE with ena, load_valid=1 SHALL enter LOAD, shift load_bit into cells (cells <= {cells[WIDTH-2:0], load_bit}), set bit count to 1.
REQ-021 In LOAD, each ena cycle with load_valid=1 SHALL shift one bit; the WIDTH-th bit SHALL return to IDLE with load_done=1 that cycle's following edge; no timeout on partial loads.
REQ-022 Next state of cell i SHALL be rule[{L,S,R}] with L=cells[i+1], S=cells[i], R=cells[i-1]; indices mod WIDTH when WRAP=1, else out-of-range reads 0.
REQ-023 In IDLE with ena, step_req=1 and load_valid=0 SHALL update cells to next generation in one cycle, increment gen_count (wrap modulo 2^GEN_W), pulse step_done, set stable = (next == cells).
REQ-024 Simultaneous load_valid and step_req in IDLE: load SHALL win; step dropped, not queued.
REQ-025 step_req during LOAD SHALL be ignored.
REQ-026 Run mode: in IDLE with ena and run=1, a prescaler SHALL count 1..P, P = max(period,1); on reaching P a step SHALL occur (as REQ-023) and prescaler restart at 1.
REQ-027 Prescaler SHALL clear when run=0 or in LOAD; step_req during run SHALL step immediately and restart prescaler.
REQ-028 stable SHALL clear on any load_done.
REQ-029 ena=0 SHALL freeze FSM, cells, counters, prescaler; pulses SHALL be 0.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE, cells=0, gen_count=0, load count=0, prescaler=0, alive=0, stable=0, step_done=0, load_done=0, load_ready=1, including mid-load.

Verification (WIDTH=8 unless stated)
REQ-031 Reset release -> cells=0x00, gen_count=0, alive=0, load_ready=1.
REQ-032 Load bits 0,0,0,1,0,0,0,0 -> cells=0x10, load_done one pulse after 8th bit; rule=0x5A step -> cells=0x28, gen_count=1, step_done pulse.
REQ-033 Load 0x01, rule=0x5A step: WRAP=1 -> 0x82; WRAP=0 -> 0x02.
REQ-034 Load 0x3C, rule=0xCC step -> cells=0x3C, stable=1, gen_count incremented.
REQ-035 run=1, period=3, rule=0x5A from 0x10 -> step_done every 3rd cycle; ena low 5 cycles -> no change, then resumes on schedule.
REQ-036 Reset after 4 load bits -> cells=0, IDLE; load_valid with step_req same cycle -> load taken, gen_count unchanged.
